// File: rtl/crc16_pkg.sv
// Shared CRC-16/CCITT-FALSE definitions for the BRAM frame generator and checker.
// Holds the polynomial, the default preset, the checker FSM encodings and the byte-step function.
package crc16_pkg;

  localparam logic [15:0] CRC_POLY         = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // One byte of MSB-first 0x1021 update; the loop unrolls into a flat XOR network.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_frame_check.sv
// Reads a stored frame (payload + 2-byte CRC, high byte first) from BRAM, recomputes
// CRC-16/CCITT-FALSE over the payload and reports pass/fail against the received CRC.
module crc16_frame_check
  import crc16_pkg::*;
#(
  parameter int          BRAM_LATENCY = 2,
  parameter int          ADDR_W       = 9,
  parameter logic [15:0] CRC_INIT     = CRC_INIT_DEFAULT
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              start_crc_chk_trig,
  input  logic [ADDR_W-1:0] bram_data_Len,
  output logic              crc_chk_busy,
  output logic              crc_chk_done,
  output logic              crc_chk_pass,
  output logic              crc_chk_len_err,
  output logic [15:0]       CRC_COMPUTED,
  output logic [15:0]       CRC_RECEIVED,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic              bram_en,
  output logic              bram_rst,
  input  logic [7:0]        BRAM_DOUT,
  output logic [1:0]        dbg_state
);

  // Handshake: start_crc_chk_trig is accepted only in IDLE (one-cycle sample, no queuing);
  // busy is high from the accepting edge until done rises; done is a level that stays high
  // until the next accepted start and qualifies pass, len_err and both CRC outputs.

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TWO = {{(ADDR_W-1){1'b0}}, 2'b10};

  logic [1:0]              state;
  logic [ADDR_W:0]         len_q;
  logic                    short_q;
  logic                    iss_act;
  logic [15:0]             crc_q;

  // Per-read tags travel alongside the BRAM pipeline so each byte is consumed when it arrives.
  logic [BRAM_LATENCY-1:0] dly_v;
  logic [BRAM_LATENCY-1:0] dly_last;
  logic [BRAM_LATENCY-1:0] dly_hi;
  logic [BRAM_LATENCY-1:0] dly_pay;

  logic                    iss_v;
  logic                    iss_last;
  logic                    iss_hi;
  logic                    iss_pay;
  logic                    cons_v;
  logic                    cons_last;
  logic                    cons_hi;
  logic                    cons_pay;

  assign bram_we   = 1'b0;
  assign bram_en   = 1'b1;
  assign bram_rst  = 1'b0;
  assign dbg_state = state;

  always_comb begin
    iss_v     = (state == ST_FETCH) && iss_act;
    iss_last  = ({1'b0, bram_addr} == (len_q - ONE));
    iss_hi    = ({1'b0, bram_addr} == (len_q - TWO));
    iss_pay   = ({1'b0, bram_addr} <  (len_q - TWO));
    cons_v    = dly_v[BRAM_LATENCY-1];
    cons_last = dly_last[BRAM_LATENCY-1];
    cons_hi   = dly_hi[BRAM_LATENCY-1];
    cons_pay  = dly_pay[BRAM_LATENCY-1];
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state           <= ST_IDLE;
      len_q           <= '0;
      short_q         <= 1'b0;
      iss_act         <= 1'b0;
      crc_q           <= CRC_INIT;
      dly_v           <= '0;
      dly_last        <= '0;
      dly_hi          <= '0;
      dly_pay         <= '0;
      crc_chk_busy    <= 1'b0;
      crc_chk_done    <= 1'b0;
      crc_chk_pass    <= 1'b0;
      crc_chk_len_err <= 1'b0;
      CRC_COMPUTED    <= '0;
      CRC_RECEIVED    <= '0;
      bram_addr       <= '0;
    end else begin
      dly_v[0]    <= iss_v;
      dly_last[0] <= iss_last;
      dly_hi[0]   <= iss_hi;
      dly_pay[0]  <= iss_pay;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        dly_v[i]    <= dly_v[i-1];
        dly_last[i] <= dly_last[i-1];
        dly_hi[i]   <= dly_hi[i-1];
        dly_pay[i]  <= dly_pay[i-1];
      end

      case (state)
        ST_IDLE: begin
          if (start_crc_chk_trig) begin
            len_q           <= {1'b0, bram_data_Len};
            short_q         <= ({1'b0, bram_data_Len} < TWO);
            iss_act         <= ({1'b0, bram_data_Len} >= TWO);
            crc_chk_busy    <= 1'b1;
            crc_chk_done    <= 1'b0;
            crc_chk_pass    <= 1'b0;
            crc_chk_len_err <= 1'b0;
            CRC_COMPUTED    <= '0;
            CRC_RECEIVED    <= '0;
            bram_addr       <= '0;
            crc_q           <= CRC_INIT;
            state           <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (iss_act) begin
            if (iss_last) iss_act   <= 1'b0;
            else          bram_addr <= bram_addr + 1'b1;
          end
          if (cons_v) begin
            if (cons_pay)  crc_q              <= crc16_ccitt_byte(crc_q, BRAM_DOUT);
            if (cons_hi)   CRC_RECEIVED[15:8] <= BRAM_DOUT;
            if (cons_last) begin
              CRC_RECEIVED[7:0] <= BRAM_DOUT;
              state             <= ST_DONE;
            end
          end
          // Too-short frames issue no reads and spend one cycle here before reporting.
          if (short_q) state <= ST_DONE;
        end

        ST_DONE: begin
          crc_chk_done <= 1'b1;
          crc_chk_busy <= 1'b0;
          state        <= ST_IDLE;
          if (short_q) begin
            crc_chk_len_err <= 1'b1;
            crc_chk_pass    <= 1'b0;
            CRC_COMPUTED    <= '0;
          end else begin
            crc_chk_len_err <= 1'b0;
            CRC_COMPUTED    <= crc_q;
            crc_chk_pass    <= (crc_q == CRC_RECEIVED);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
